// File: rtl/uart_rx_read_ctrl_if.sv
// Byte-stream handshake between the RX read controller and its consumer.
// The master drives valid/data/err and the slave returns ready.
interface uart_rx_read_ctrl_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_err;

  modport master (
    output m_valid,
    output m_data,
    output m_err,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_read_ctrl.sv
// Drains 11-bit frames from the RX FIFO, checks start/stop/parity and hands the
// payload byte to a valid/ready consumer while keeping saturating error counts.
module uart_rx_read_ctrl #(
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned DROP_ERR   = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_empty,
  output logic                 rd_en,
  input  logic [10:0]          data_out,
  uart_rx_read_ctrl_if.master  m_if,
  input  logic                 clr_err,
  output logic [CNT_W-1:0]     par_err_cnt,
  output logic [CNT_W-1:0]     frm_err_cnt
);

  localparam logic             ParityRef = (PARITY_ODD != 0);
  localparam logic             DropErr   = (DROP_ERR != 0);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRead, StCheck, StHold} state_e;

  state_e state;
  logic   frm_bad;
  logic   par_bad;
  logic   any_bad;

  assign frm_bad = data_out[0] | ~data_out[10];
  assign par_bad = (^data_out[9:1]) != ParityRef;
  assign any_bad = frm_bad | par_bad;

  // Pop strobe is decoded from IDLE so the FIFO sees it in the same cycle the
  // non-empty flag is observed; gated by reset so an aborted cycle pops nothing.
  assign rd_en = (state == StIdle) & ~rx_empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      m_if.m_valid <= 1'b0;
      m_if.m_data  <= 8'h00;
      m_if.m_err   <= 1'b0;
      par_err_cnt  <= '0;
      frm_err_cnt  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (!rx_empty) begin
            state <= StRead;
          end
        end
        StRead: begin
          state <= StCheck;
        end
        StCheck: begin
          if (any_bad && DropErr) begin
            state <= StIdle;
          end else begin
            m_if.m_data  <= data_out[8:1];
            m_if.m_err   <= any_bad;
            m_if.m_valid <= 1'b1;
            state        <= StHold;
          end
        end
        StHold: begin
          if (m_if.m_ready) begin
            m_if.m_valid <= 1'b0;
            state        <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase

      // Clear takes priority over a coincident CHECK increment.
      if (clr_err) begin
        par_err_cnt <= '0;
        frm_err_cnt <= '0;
      end else if (state == StCheck) begin
        if (par_bad && (par_err_cnt != '1)) begin
          par_err_cnt <= par_err_cnt + CntOne;
        end
        if (frm_bad && (frm_err_cnt != '1)) begin
          frm_err_cnt <= frm_err_cnt + CntOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_read_ctrl.sv
// Drives two differently configured controllers from a shared frame stream and
// compares every cycle against a transaction-timing reference model.
module tb_uart_rx_read_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic        push = 1'b0;
  logic [10:0] push_data = '0;
  logic        started = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [10:0] f);
    push      = 1'b1;
    push_data = f;
    tick(1);
    push      = 1'b0;
  endtask

  // Instance 0: even parity, drop errored frames, 2-bit counters.
  // Instance 1: odd parity, forward errored frames, 8-bit counters.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int unsigned Podd   = gi;
    localparam int unsigned Drop   = (gi == 0) ? 1 : 0;
    localparam int unsigned Cw     = (gi == 0) ? 2 : 8;
    localparam int          CntMax = (1 << Cw) - 1;

    uart_rx_read_ctrl_if bus ();

    logic          rx_empty = 1'b1;
    logic          rd_en;
    logic [10:0]   data_out = '0;
    logic [Cw-1:0] par_cnt;
    logic [Cw-1:0] frm_cnt;

    assign bus.m_ready = m_ready;

    uart_rx_read_ctrl #(
      .PARITY_ODD (Podd),
      .DROP_ERR   (Drop),
      .CNT_W      (Cw)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_empty    (rx_empty),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .m_if        (bus),
      .clr_err     (clr_err),
      .par_err_cnt (par_cnt),
      .frm_err_cnt (frm_cnt)
    );

    // FIFO with registered read data; not affected by the controller's reset.
    logic [10:0] fifo_q[$];
    always @(posedge clk) begin
      if (rd_en && fifo_q.size() > 0) data_out <= fifo_q.pop_front();
      if (push) fifo_q.push_back(push_data);
      rx_empty <= (fifo_q.size() == 0);
    end

    // Reference: a read starts a frame, the frame is judged two cycles later,
    // and a presented byte is held until the consumer takes it.
    int          age = -1;
    bit          presenting = 1'b0;
    logic [10:0] frame = '0;
    bit          e_valid = 1'b0;
    logic [7:0]  e_data = '0;
    bit          e_err = 1'b0;
    int          e_par = 0;
    int          e_frm = 0;

    always @(negedge clk) begin
      bit exp_rd;
      bit fb;
      bit pb;
      if (started) begin
        check_eq($sformatf("d%0d.m_valid", gi), 32'(bus.m_valid), 32'(e_valid));
        check_eq($sformatf("d%0d.m_data", gi), 32'(bus.m_data), 32'(e_data));
        check_eq($sformatf("d%0d.m_err", gi), 32'(bus.m_err), 32'(e_err));
        check_eq($sformatf("d%0d.par_cnt", gi), 32'(par_cnt), 32'(e_par));
        check_eq($sformatf("d%0d.frm_cnt", gi), 32'(frm_cnt), 32'(e_frm));
        exp_rd = !rst && (age < 0) && !presenting && !rx_empty;
        check_eq($sformatf("d%0d.rd_en", gi), 32'(rd_en), 32'(exp_rd));

        if (rst) begin
          age        = -1;
          presenting = 1'b0;
          e_valid    = 1'b0;
          e_data     = '0;
          e_err      = 1'b0;
          e_par      = 0;
          e_frm      = 0;
        end else begin
          fb = (frame[0] != 1'b0) || (frame[10] != 1'b1);
          pb = ($countones(frame[9:1]) % 2) != Podd;
          if (clr_err) begin
            e_par = 0;
            e_frm = 0;
          end else if (age == 2) begin
            if (pb && e_par < CntMax) e_par = e_par + 1;
            if (fb && e_frm < CntMax) e_frm = e_frm + 1;
          end
          if (presenting && m_ready) begin
            presenting = 1'b0;
            e_valid    = 1'b0;
          end
          if (age == 2) begin
            if (!((fb || pb) && Drop != 0)) begin
              e_data     = frame[8:1];
              e_err      = fb || pb;
              e_valid    = 1'b1;
              presenting = 1'b1;
            end
            age = -1;
          end else if (age >= 0) begin
            age = age + 1;
          end
          if (exp_rd && fifo_q.size() > 0) begin
            frame = fifo_q[0];
            age   = 1;
          end
        end
      end
    end
  end

  function automatic logic [10:0] good_even(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  initial begin
    logic [10:0] f;
    rst = 1'b1;
    tick(3);
    started = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Clean frame: start 0, data 0xD5, parity 1, stop 1.
    m_ready = 1'b1;
    push_frame(11'h7AA);
    tick(8);

    // Parity fault then framing fault.
    push_frame(11'h402);
    tick(8);
    push_frame(11'h203);
    tick(8);

    // Backpressure with three queued good frames.
    m_ready = 1'b0;
    push_frame(good_even(8'h11));
    push_frame(good_even(8'h22));
    push_frame(good_even(8'h33));
    tick(10);
    m_ready = 1'b1;
    tick(20);

    // Saturate the small counters, then clear exactly on the 6th frame's CHECK.
    for (int i = 0; i < 5; i++) begin
      push_frame(11'h402);
      tick(6);
    end
    push_frame(11'h402);
    tick(2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(6);

    // Reset landing on CHECK, then on HOLD, then a normal restart.
    push_frame(good_even(8'h5C));
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    m_ready = 1'b0;
    push_frame(good_even(8'hA7));
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_ready = 1'b1;
    tick(2);
    push_frame(good_even(8'h3E));
    tick(8);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      push = ($urandom_range(3) == 0);
      f = 11'($urandom_range(2047));
      if ($urandom_range(1) == 1) f = good_even(f[8:1]);
      push_data = f;
      m_ready = ($urandom_range(1) == 1);
      clr_err = ($urandom_range(31) == 0);
      rst = ($urandom_range(127) == 0);
      tick(1);
    end
    push = 1'b0;
    clr_err = 1'b0;
    rst = 1'b0;
    m_ready = 1'b1;
    tick(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
